// File: rtl/gpu_cmd_issuer.sv
// gpu_cmd_issuer: host-side initiator that sequences copy and kernel-launch commands
// onto the GPU controller's instruction/data/ack handshake.
module gpu_cmd_issuer #(
    parameter int data_width     = 32,
    parameter int addr_width     = 32,
    parameter int count_width    = 16,
    parameter int timeout_cycles = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [1:0]             req_op,
    input  logic [addr_width-1:0]  req_gpu_addr,
    input  logic [count_width-1:0] req_count,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [count_width-1:0] local_rd_addr,
    input  logic [data_width-1:0]  local_rd_data,
    output logic                   local_wr_en,
    output logic [count_width-1:0] local_wr_addr,
    output logic [data_width-1:0]  local_wr_data,
    output logic [31:0]            gpu_instr,
    output logic [data_width-1:0]  gpu_in_data,
    input  logic [data_width-1:0]  gpu_out_data,
    input  logic                   gpu_out_ack
);
    localparam int tw = $clog2(timeout_cycles + 1);
    localparam logic [1:0] op_to = 2'd1, op_from = 2'd2, op_launch = 2'd3;

    typedef enum logic [2:0] {IDLE, SEND_ADDR, SEND_COUNT, SEND_DATA, WAIT_ACK, RECV_DATA} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [addr_width-1:0]  addr_q, addr_d;
    logic [count_width-1:0] cnt_q, cnt_d;
    logic [count_width-1:0] idx_q, idx_d;
    logic [tw-1:0]          tmo_q, tmo_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   tmo_hit;

    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign err     = err_q;
    assign tmo_hit = tmo_q == tw'(timeout_cycles - 1);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        tmo_d         = '0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        gpu_instr     = '0;
        gpu_in_data   = '0;
        local_rd_addr = '0;
        local_wr_en   = 1'b0;
        local_wr_addr = '0;
        local_wr_data = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_gpu_addr;
                    cnt_d   = req_count;
                    idx_d   = '0;
                    err_d   = req_op == 2'd0;
                    state_d = req_op == 2'd0 ? IDLE : SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                gpu_instr   = {30'b0, op_q};
                gpu_in_data = data_width'(addr_q);
                state_d     = op_q == op_launch ? WAIT_ACK : SEND_COUNT;
            end
            SEND_COUNT: begin
                // local_rd_addr stays 0 here so word 0 is ready on the first data cycle
                gpu_in_data = data_width'(cnt_q);
                done_d      = cnt_q == '0 && op_q == op_from;
                state_d     = cnt_q == '0 ? (op_q == op_from ? IDLE : WAIT_ACK)
                                          : (op_q == op_to ? SEND_DATA : RECV_DATA);
            end
            SEND_DATA: begin
                gpu_in_data   = local_rd_data;
                local_rd_addr = idx_q + 1'b1;
                idx_d         = idx_q + 1'b1;
                state_d       = idx_q == cnt_q - 1'b1 ? WAIT_ACK : SEND_DATA;
            end
            WAIT_ACK: begin
                done_d  = gpu_out_ack;
                err_d   = !gpu_out_ack && tmo_hit;
                tmo_d   = gpu_out_ack ? '0 : tmo_q + 1'b1;
                state_d = gpu_out_ack || tmo_hit ? IDLE : WAIT_ACK;
            end
            RECV_DATA: begin
                local_wr_addr = idx_q;
                local_wr_en   = gpu_out_ack;
                local_wr_data = gpu_out_ack ? gpu_out_data : '0;
                idx_d         = gpu_out_ack ? idx_q + 1'b1 : idx_q;
                done_d        = gpu_out_ack && idx_q == cnt_q - 1'b1;
                err_d         = !gpu_out_ack && tmo_hit;
                tmo_d         = gpu_out_ack ? '0 : tmo_q + 1'b1;
                state_d       = done_d || err_d ? IDLE : RECV_DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_gpu_cmd_issuer.sv
// tb_gpu_cmd_issuer: scoreboard bench; a timeline model queues expected output cycles,
// a negedge monitor pops and compares them whenever the issuer shows activity.
module tb_gpu_cmd_issuer;
    localparam int DW = 32, AW = 32, CW = 4, T = 16, TL = 64;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic [1:0] req_op;
    logic [AW-1:0] req_gpu_addr;
    logic [CW-1:0] req_count;
    logic busy, done, err, local_wr_en;
    logic [CW-1:0] local_rd_addr, local_wr_addr;
    logic [DW-1:0] local_rd_data, local_wr_data, gpu_in_data, gpu_out_data;
    logic [31:0] gpu_instr;
    logic gpu_out_ack;
    logic l_busy, l_done, l_err, l_wr_en;
    logic [CW-1:0] l_rd_addr, l_wr_addr;
    logic [DW-1:0] l_wr_data, l_in_data;
    logic [31:0] l_instr;

    always #5 clk = ~clk;

    gpu_cmd_issuer #(.data_width(DW), .addr_width(AW), .count_width(CW), .timeout_cycles(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_gpu_addr(req_gpu_addr),
        .req_count(req_count), .busy(busy), .done(done), .err(err), .local_rd_addr(local_rd_addr),
        .local_rd_data(local_rd_data), .local_wr_en(local_wr_en), .local_wr_addr(local_wr_addr),
        .local_wr_data(local_wr_data), .gpu_instr(gpu_instr), .gpu_in_data(gpu_in_data),
        .gpu_out_data(gpu_out_data), .gpu_out_ack(gpu_out_ack));

    // long-timeout instance used only for the 50-cycle kernel-launch ack
    gpu_cmd_issuer #(.data_width(DW), .addr_width(AW), .count_width(CW), .timeout_cycles(TL)) u_l (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_gpu_addr(req_gpu_addr),
        .req_count(req_count), .busy(l_busy), .done(l_done), .err(l_err), .local_rd_addr(l_rd_addr),
        .local_rd_data(local_rd_data), .local_wr_en(l_wr_en), .local_wr_addr(l_wr_addr),
        .local_wr_data(l_wr_data), .gpu_instr(l_instr), .gpu_in_data(l_in_data),
        .gpu_out_data(gpu_out_data), .gpu_out_ack(gpu_out_ack));

    logic [DW-1:0] mem [16];
    always @(posedge clk) local_rd_data <= mem[local_rd_addr];

    typedef struct packed {
        logic busy;
        logic [31:0] instr;
        logic [DW-1:0] din;
        logic wen;
        logic [CW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic done;
        logic err;
    } obs_t;

    obs_t sb[$];
    int passed = 0, total = 0;
    int g [16];
    logic [DW-1:0] rdv [16];

    function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endfunction

    function automatic obs_t mk(logic b, logic [31:0] ins, logic [DW-1:0] d, logic w,
                                logic [CW-1:0] wa, logic [DW-1:0] wd, logic dn, logic er);
        obs_t o;
        o.busy = b; o.instr = ins; o.din = d; o.wen = w;
        o.waddr = wa; o.wdata = wd; o.done = dn; o.err = er;
        return o;
    endfunction

    // expected cycle-by-cycle activity of one command, from the protocol rules
    function automatic void push_cmd(logic [1:0] op, logic [AW-1:0] addr, logic [CW-1:0] cnt);
        int n;
        if (op == 0) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        sb.push_back(mk(1, 32'(op), DW'(addr), 0, 0, 0, 0, 0));
        if (op != 3) begin
            sb.push_back(mk(1, 0, DW'(cnt), 0, 0, 0, 0, 0));
            if (op == 1)
                for (int k = 0; k < int'(cnt); k++) sb.push_back(mk(1, 0, mem[k], 0, 0, 0, 0, 0));
        end
        if (op == 2 && cnt == 0) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
            return;
        end
        n = op == 2 ? int'(cnt) : 1;
        for (int i = 0; i < n; i++) begin
            if (g[i] >= T) begin
                repeat (T) sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
                sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
                return;
            end
            repeat (g[i]) sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
            sb.push_back(mk(1, 0, 0, op == 2, CW'(i), op == 2 ? rdv[i] : '0, 0, 0));
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    endfunction

    always @(negedge clk) begin
        obs_t a, e;
        if (busy === 1'b1 || done === 1'b1 || err === 1'b1) begin
            a = mk(busy, gpu_instr, gpu_in_data, local_wr_en, local_wr_addr, local_wr_data, done, err);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_activity: got %0h expected nothing", a);
            end else begin
                e = sb.pop_front();
                if (!e.wen) begin a.waddr = '0; a.wdata = '0; end
                chk("trace", 128'(a), 128'(e));
            end
        end
    end

    task automatic junk();
        req_valid = 1'($urandom_range(0, 1));
        req_op = 2'($urandom);
        req_count = CW'($urandom);
        req_gpu_addr = $urandom;
        gpu_out_ack = 1'($urandom_range(0, 1));
        gpu_out_data = $urandom;
    endtask

    task automatic issue(logic [1:0] op, logic [AW-1:0] addr, logic [CW-1:0] cnt);
        req_valid = 1; req_op = op; req_gpu_addr = addr; req_count = cnt;
        @(posedge clk) #1;
        req_valid = 0;
    endtask

    task automatic run(logic [1:0] op, logic [AW-1:0] addr, logic [CW-1:0] cnt);
        int pre, n;
        push_cmd(op, addr, cnt);
        issue(op, addr, cnt);
        if (op != 0) begin
            pre = op == 3 ? 1 : op == 1 ? 2 + int'(cnt) : 2;
            repeat (pre) begin junk(); @(posedge clk) #1; end
            req_valid = 0; gpu_out_ack = 0;
            n = op == 2 ? int'(cnt) : 1;
            for (int i = 0; i < n; i++) begin
                if (g[i] >= T) begin
                    repeat (T) @(posedge clk) #1;
                    break;
                end
                repeat (g[i]) begin
                    req_valid = 1'($urandom_range(0, 1)); req_op = 2'($urandom); gpu_out_data = $urandom;
                    @(posedge clk) #1;
                end
                req_valid = 0; gpu_out_ack = 1; gpu_out_data = op == 2 ? rdv[i] : $urandom;
                @(posedge clk) #1;
                gpu_out_ack = 0;
            end
        end
        repeat (2) begin gpu_out_ack = 1'($urandom_range(0, 1)); @(posedge clk) #1; end
        gpu_out_ack = 0;
    endtask

    function automatic logic [127:0] all_out();
        return 128'({busy, done, err, gpu_instr, gpu_in_data, local_wr_en, local_wr_addr,
                     local_wr_data, local_rd_addr});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1; req_valid = 0; req_op = 0; req_gpu_addr = 0; req_count = 0;
        gpu_out_data = 0; gpu_out_ack = 0;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset_outputs", all_out(), 0);

        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; g[0] = 4;
        run(1, 32'h100, 3);
        g[0] = 2; g[1] = 5; rdv[0] = 32'h11; rdv[1] = 32'h22;
        run(2, 32'h40, 2);
        g[0] = 3;
        run(1, 32'h300, 0);
        run(2, 32'h340, 0);
        run(0, 32'h123, 5);
        for (int k = 0; k < 16; k++) begin mem[k] = $urandom; g[k] = k % 4; rdv[k] = $urandom; end
        run(1, 32'h500, 15);
        run(2, 32'h600, 15);

        g[0] = 49;
        push_cmd(3, 32'h80, 0);
        issue(3, 32'h80, 0);
        repeat (50) @(posedge clk) #1;
        gpu_out_ack = 1;
        @(posedge clk) #1;
        gpu_out_ack = 0;
        chk("launch_long_done", {l_done, l_err, l_busy}, 3'b100);
        repeat (2) @(posedge clk) #1;

        g[0] = T;
        run(3, 32'h80, 0);

        mem[0] = 32'h1111; mem[1] = 32'h2222; mem[2] = 32'h3333;
        sb.push_back(mk(1, 1, 32'h200, 0, 0, 0, 0, 0));
        sb.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0));
        sb.push_back(mk(1, 0, 32'h1111, 0, 0, 0, 0, 0));
        sb.push_back(mk(1, 0, 32'h2222, 0, 0, 0, 0, 0));
        issue(1, 32'h200, 3);
        repeat (3) @(posedge clk) #1;
        rst = 1;
        @(posedge clk) #1;
        rst = 0;
        chk("reset_mid_cmd", all_out(), 0);
        chk("reset_sb_empty", 128'(sb.size()), 0);
        g[0] = 1;
        run(1, 32'h210, 3);

        for (int it = 0; it < 40; it++) begin
            logic [1:0] op;
            logic [CW-1:0] cnt;
            op = 2'($urandom_range(0, 3));
            cnt = $urandom_range(0, 9) == 0 ? CW'(15) : CW'($urandom);
            for (int k = 0; k < 16; k++) begin
                mem[k] = $urandom;
                rdv[k] = $urandom;
                g[k] = $urandom_range(0, 24) == 0 ? T : $urandom_range(0, T - 1);
            end
            run(op, $urandom, cnt);
        end

        repeat (3) @(posedge clk) #1;
        chk("sb_drained", 128'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gpu_cmd_issuer.md
GPU_CMD_ISSUER -- requirements
Module: gpu_cmd_issuer

Interface
REQ-001 SHALL have parameter data_width, default 32, meaning width of GPU data words and command payloads.
REQ-002 SHALL have parameter addr_width, default 32, meaning width of GPU global-memory addresses.
REQ-003 SHALL have parameter count_width, default 16, meaning width of transfer word count and local buffer address.
REQ-004 SHALL have parameter timeout_cycles, default 1024, meaning the maximum number of cycles to wait for any single gpu_out_ack.
REQ-005 SHALL have the following ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  start-command strobe from host CPU logic
- req_op  in  2  operation: 1=COPY_TO_GPU, 2=COPY_FROM_GPU, 3=KERNEL_LAUNCH; 0 illegal
- req_gpu_addr  in  addr_width  GPU memory address (copy ops) or kernel start PC (launch)
- req_count  in  count_width  number of words to copy
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes successfully
- err  out  1  one-cycle pulse on timeout or illegal op
- local_rd_addr  out  count_width  host buffer read address
- local_rd_data  in  data_width  host buffer read data, valid 1 cycle after local_rd_addr
- local_wr_en  out  1  host buffer write strobe
- local_wr_addr  out  count_width  host buffer write address
- local_wr_data  out  data_width  host buffer write data
- gpu_instr  out  32  drives GPU cpu_recv_instr
- gpu_in_data  out  data_width  drives GPU cpu_in_data
- gpu_out_data  in  data_width  GPU cpu_out_data
- gpu_out_ack  in  1  GPU cpu_out_ack

Function
REQ-006 SHALL implement the initiator side of the GPU controller's host protocol; gpu_instr codes: 0=NOP, 1=COPY_TO_GPU, 2=COPY_FROM_GPU, 3=KERNEL_LAUNCH.
REQ-007 SHALL use states IDLE, SEND_ADDR, SEND_COUNT, SEND_DATA, WAIT_ACK, RECV_DATA.
REQ-008 SHALL, in IDLE, drive gpu_instr=0 and gpu_in_data=0, and accept a request only when req_valid=1; it SHALL latch op, addr and count on that edge.
REQ-009 SHALL, when req_op=0 is accepted, pulse err for one cycle and remain in IDLE.
REQ-010 SHALL, in SEND_ADDR (one cycle), drive gpu_instr=op and gpu_in_data=latched addr; it SHALL then go to SEND_COUNT for copies and to WAIT_ACK for KERNEL_LAUNCH.
REQ-011 SHALL, in SEND_COUNT (one cycle), drive gpu_instr=0 and gpu_in_data=count zero-extended.
REQ-012 SHALL, in SEND_COUNT, drive local_rd_addr=0 for COPY_TO_GPU so that the first word is prefetched.
REQ-013 SHALL, after SEND_COUNT, go to SEND_DATA for COPY_TO_GPU with count>0 and to RECV_DATA for COPY_FROM_GPU with count>0.
REQ-014 SHALL, when count=0, go from SEND_COUNT to WAIT_ACK for COPY_TO_GPU and pulse done immediately to IDLE for COPY_FROM_GPU.
REQ-015 SHALL, in SEND_DATA word k (k=0..count-1, one word per cycle, no stalls), drive gpu_in_data=local_rd_data and local_rd_addr=k+1.
REQ-016 SHALL go to WAIT_ACK after SEND_DATA word count-1.
REQ-017 SHALL, in WAIT_ACK, pulse done and return to IDLE on the cycle after gpu_out_ack=1; for KERNEL_LAUNCH this ack signals core halt.
REQ-018 SHALL, in RECV_DATA, on each gpu_out_ack=1, assert local_wr_en with local_wr_addr=index and local_wr_data=gpu_out_data, then increment index.
REQ-019 SHALL pulse done and return to IDLE on the cycle after the count-th ack in RECV_DATA.
REQ-020 SHALL keep a timeout counter in WAIT_ACK and RECV_DATA that clears on entry and on every ack; if it reaches timeout_cycles-1 without an ack, it SHALL pulse err and return to IDLE with no done pulse.
REQ-021 SHALL ignore gpu_out_ack in IDLE, SEND_ADDR, SEND_COUNT and SEND_DATA.
REQ-022 SHALL ignore req_valid while busy=1; requests are not queued.
REQ-023 SHALL drive busy=1 in every state except IDLE; done and err SHALL never assert in the same cycle.
REQ-024 SHALL keep local_wr_en=0 outside RECV_DATA.
REQ-025 SHALL keep index and count arithmetic at count_width bits; a count of 2^count_width-1 SHALL complete without wrap.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, go to IDLE and clear busy, done, err, local_wr_en, gpu_instr, gpu_in_data, local_rd_addr, local_wr_addr, local_wr_data and all counters to 0.
REQ-027 SHALL, on reset mid-command, abandon the command with no done or err pulse, and gpu_instr SHALL be 0 on the following cycle.

Verification
REQ-028 SHALL cover: COPY_TO_GPU addr=0x100, count=3, buffer {A,B,C} -> gpu_instr 1 for one cycle, gpu_in_data sequence 0x100,3,A,B,C, then ack -> done one cycle later.
REQ-029 SHALL cover: COPY_FROM_GPU addr=0x40, count=2, acks with data 0x11 and 0x22 separated by 5 idle cycles -> local writes at addr0=0x11 and addr1=0x22, then done.
REQ-030 SHALL cover: KERNEL_LAUNCH pc=0x80 -> gpu_instr=3 with gpu_in_data=0x80 for one cycle; ack after 50 cycles -> done.
REQ-031 SHALL cover: KERNEL_LAUNCH with no ack and timeout_cycles=16 -> err pulse at cycle 16 of WAIT_ACK, busy=0, no done.
REQ-032 SHALL cover: count=0 copies (immediate done for FROM, ack-gated done for TO), and req_op=0 -> err pulse with busy never asserted.
REQ-033 SHALL cover: rst asserted during SEND_DATA word 1 -> IDLE, all outputs 0, and a new request afterwards runs correctly.
